// File: rtl/sha256_msg_padder_if.sv
// Word-stream input and padded-block output of the SHA-256 message padder.
// slave is the padder side; master is the producer/consumer side.
interface sha256_msg_padder_if;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic [1:0]   in_nbytes;
    logic         in_ready;
    logic [511:0] block_out;
    logic         block_valid;
    logic         block_ready;
    logic         block_last;

    modport slave (
        input  in_data, in_valid, in_last, in_nbytes, block_ready,
        output in_ready, block_out, block_valid, block_last
    );

    modport master (
        output in_data, in_valid, in_last, in_nbytes, block_ready,
        input  in_ready, block_out, block_valid, block_last
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs big-endian words into 512-bit blocks, appends 0x80 and the 64-bit length.
// Optional block counter output blk_count is enabled by defining SHA256_PADDER_BLKCNT_EN.
module sha256_msg_padder #(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    sha256_msg_padder_if.slave bus
`ifdef SHA256_PADDER_BLKCNT_EN
    ,
    output logic [31:0]        blk_count
`endif
);

    if (WORD_WIDTH != 32) begin : g_width_check
        $error("sha256_msg_padder supports only WORD_WIDTH = 32");
    end

    typedef enum logic [1:0] {
        ACCUM,
        EMIT,
        EMIT_EXTRA
    } state_t;

    state_t            state_q;
    logic [3:0]        wi_q;
    logic [63:0]       len_q;
    logic [15:0][31:0] blk_q;
    logic              in_ready_q;
    logic              block_valid_q;
    logic              block_last_q;
    logic              extra_q;
    logic              extra_mark_q;

    logic              in_hs;
    logic              blk_hs;
    logic [2:0]        nbytes_d;
    logic [31:0]       last_word_d;
    logic [63:0]       len_d;
    logic              fits_d;
    logic [15:0][31:0] pad_blk_d;

    assign in_hs  = bus.in_valid & in_ready_q;
    assign blk_hs = block_valid_q & bus.block_ready;

    // Word i of the block lives at blk_q[15-i] so word 0 lands in block_out[511:480].
    always_comb begin
        nbytes_d = (bus.in_nbytes == 2'd0) ? 3'd4 : {1'b0, bus.in_nbytes};
        case (bus.in_nbytes)
            2'd1:    last_word_d = {bus.in_data[31:24], 8'h80, 16'h0000};
            2'd2:    last_word_d = {bus.in_data[31:16], 8'h80, 8'h00};
            2'd3:    last_word_d = {bus.in_data[31:8], 8'h80};
            default: last_word_d = bus.in_data;
        endcase
        len_d  = len_q + {58'd0, nbytes_d, 3'd0};
        // The length fits only if the 0x80 marker lands in word 13 or lower.
        fits_d = (bus.in_nbytes == 2'd0) ? (wi_q <= 4'd12) : (wi_q <= 4'd13);
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < 32'(wi_q))
                pad_blk_d[15-i] = blk_q[15-i];
            else if (i == 32'(wi_q))
                pad_blk_d[15-i] = last_word_d;
            else if ((i == 32'(wi_q) + 1) && (bus.in_nbytes == 2'd0))
                pad_blk_d[15-i] = 32'h8000_0000;
            else
                pad_blk_d[15-i] = '0;
        end
        if (fits_d) begin
            pad_blk_d[1] = len_d[63:32];
            pad_blk_d[0] = len_d[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ACCUM;
            wi_q          <= '0;
            len_q         <= '0;
            blk_q         <= '0;
            in_ready_q    <= 1'b1;
            block_valid_q <= 1'b0;
            block_last_q  <= 1'b0;
            extra_q       <= 1'b0;
            extra_mark_q  <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_hs) begin
                        if (bus.in_last) begin
                            blk_q         <= pad_blk_d;
                            len_q         <= len_d;
                            wi_q          <= '0;
                            state_q       <= EMIT;
                            in_ready_q    <= 1'b0;
                            block_valid_q <= 1'b1;
                            block_last_q  <= fits_d;
                            extra_q       <= ~fits_d;
                            extra_mark_q  <= (wi_q == 4'd15) && (bus.in_nbytes == 2'd0);
                        end else begin
                            blk_q[~wi_q] <= bus.in_data;
                            len_q        <= len_q + 64'd32;
                            wi_q         <= wi_q + 4'd1;
                            if (wi_q == 4'd15) begin
                                state_q       <= EMIT;
                                in_ready_q    <= 1'b0;
                                block_valid_q <= 1'b1;
                                block_last_q  <= 1'b0;
                                extra_q       <= 1'b0;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (blk_hs) begin
                        if (extra_q) begin
                            // Extra block follows immediately; block_valid stays high.
                            blk_q        <= {(extra_mark_q ? 32'h8000_0000 : 32'h0), 416'd0, len_q};
                            state_q      <= EMIT_EXTRA;
                            block_last_q <= 1'b1;
                            extra_q      <= 1'b0;
                        end else begin
                            state_q       <= ACCUM;
                            wi_q          <= '0;
                            in_ready_q    <= 1'b1;
                            block_valid_q <= 1'b0;
                            block_last_q  <= 1'b0;
                            if (block_last_q)
                                len_q <= '0;
                        end
                    end
                end
                EMIT_EXTRA: begin
                    if (blk_hs) begin
                        state_q       <= ACCUM;
                        wi_q          <= '0;
                        len_q         <= '0;
                        in_ready_q    <= 1'b1;
                        block_valid_q <= 1'b0;
                        block_last_q  <= 1'b0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

`ifdef SHA256_PADDER_BLKCNT_EN
    logic [31:0] blk_count_q;

    always_ff @(posedge clk) begin
        if (rst)
            blk_count_q <= '0;
        else if (blk_hs)
            blk_count_q <= blk_count_q + 32'd1;
    end

    assign blk_count = blk_count_q;
`endif

    assign bus.in_ready    = in_ready_q;
    assign bus.block_out   = blk_q;
    assign bus.block_valid = block_valid_q;
    assign bus.block_last  = block_last_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: a byte-level padding model queues expected blocks per message.
// Define SHA256_PADDER_BLKCNT_EN to also exercise the blk_count output.
module tb_sha256_msg_padder;

    typedef struct {
        logic [511:0] data;
        logic         last;
        logic         nogap;
    } blk_t;

    logic clk = 1'b0;
    logic rst;
    logic stall;
    int   n_checks = 0;
    int   n_pass   = 0;
    blk_t sb[$];

    always #5 clk = ~clk;

    sha256_msg_padder_if bus ();

`ifdef SHA256_PADDER_BLKCNT_EN
    logic [31:0] blk_count;
`endif

    sha256_msg_padder #(.WORD_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SHA256_PADDER_BLKCNT_EN
        ,
        .blk_count (blk_count)
`endif
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference padding at byte level: msg || 0x80 || zeros || 64-bit big-endian bit length.
    task automatic push_expected(input byte unsigned msg[$]);
        byte unsigned p[$];
        logic [63:0]  bits;
        int unsigned  nb;
        blk_t         e;
        p    = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56)
            p.push_back(8'h00);
        for (int i = 7; i >= 0; i--)
            p.push_back(bits[8*i +: 8]);
        nb = p.size() / 64;
        for (int unsigned b = 0; b < nb; b++) begin
            e.data = '0;
            for (int unsigned j = 0; j < 64; j++)
                e.data[511 - 8*j -: 8] = p[b*64 + j];
            e.last  = (b == nb - 1);
            e.nogap = (b == nb - 2) && (msg.size() <= (nb - 1) * 64);
            sb.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
        int unsigned t    = 0;
        logic        acc  = 1'b0;
        logic        done = 1'b0;
        bus.in_data   = d;
        bus.in_last   = last;
        bus.in_nbytes = nb;
        bus.in_valid  = 1'b1;
        while (!done) begin
            acc = bus.in_ready;
            @(posedge clk);
            @(negedge clk);
            t++;
            if (acc || t >= 2000)
                done = 1'b1;
        end
        if (!acc)
            check("in_accept", acc, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_msg(input byte unsigned msg[$]);
        int unsigned nw;
        logic [31:0] d;
        nw = (msg.size() + 3) / 4;
        push_expected(msg);
        for (int unsigned w = 0; w < nw; w++) begin
            d = $urandom;
            for (int unsigned b = 0; b < 4; b++)
                if (w*4 + b < msg.size())
                    d[31 - 8*b -: 8] = msg[w*4 + b];
            send_word(d, (w == nw - 1), 2'(msg.size() % 4));
        end
    endtask

    task automatic rand_msg(input int unsigned n, output byte unsigned m[$]);
        m = {};
        for (int unsigned i = 0; i < n; i++)
            m.push_back(8'($urandom));
    endtask

    task automatic wait_drain();
        int unsigned t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(sb.size()), 0);
        @(negedge clk);
    endtask

    // Block consumer: drives block_ready, pops the scoreboard on each handshake.
    initial begin : monitor
        blk_t         e;
        logic [511:0] held;
        logic         held_last;
        logic         holding   = 1'b0;
        logic         nogap_chk = 1'b0;
        bus.block_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (nogap_chk) begin
                check("no_gap", bus.block_valid, 1);
                nogap_chk = 1'b0;
            end
            if (holding) begin
                check("hold_data", bus.block_out, held);
                check("hold_last", bus.block_last, held_last);
            end
            holding         = 1'b0;
            bus.block_ready = ~stall;
            if (bus.block_valid && !stall) begin
                if (sb.size() == 0) begin
                    check("unexpected_block", bus.block_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("block_data", bus.block_out, e.data);
                    check("block_last", bus.block_last, e.last);
                    nogap_chk = e.nogap;
                end
            end else if (bus.block_valid) begin
                held      = bus.block_out;
                held_last = bus.block_last;
                holding   = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        byte unsigned m[$];
        int unsigned  lens[14] = '{1, 4, 52, 53, 55, 57, 59, 60, 61, 63, 65, 119, 120, 128};
        int unsigned  t;

        stall         = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_nbytes = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_block_valid", bus.block_valid, 0);
        check("rst_block_last", bus.block_last, 0);
        check("rst_block_out", bus.block_out, 0);

        m = {8'h61, 8'h62, 8'h63};
        send_msg(m);
        wait_drain();

        rand_msg(56, m);
        send_msg(m);
        wait_drain();

        rand_msg(64, m);
        send_msg(m);
        wait_drain();

        foreach (lens[i]) begin
            rand_msg(lens[i], m);
            send_msg(m);
            wait_drain();
        end

        // Consumer stalls while the producer keeps offering words.
        stall = 1'b1;
        rand_msg(80, m);
        fork
            send_msg(m);
            begin
                t = 0;
                while (!bus.block_valid && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                check("stall_block_valid", bus.block_valid, 1);
                repeat (10) begin
                    @(negedge clk);
                    check("stall_in_ready", bus.in_ready, 0);
                end
                stall = 1'b0;
            end
        join
        wait_drain();
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m);
        wait_drain();

        // Reset after five accepted words discards the partial message.
        for (int unsigned w = 0; w < 5; w++)
            send_word($urandom, 1'b0, 2'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_block_valid", bus.block_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m);
        wait_drain();
        rand_msg(56, m);
        send_msg(m);
        wait_drain();
`ifdef SHA256_PADDER_BLKCNT_EN
        check("blk_count", blk_count, 3);
`endif

        for (int unsigned r = 0; r < 6; r++) begin
            rand_msg($urandom_range(1, 140), m);
            send_msg(m);
            wait_drain();
        end

        check("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, meaning input word width; only the value 32 is supported.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port in_data, input, 32: message word, big-endian; the first message byte is in bits [31:24].
REQ-006 SHALL have port in_valid, input, 1: in_data is valid.
REQ-007 SHALL have port in_last, input, 1: the current word is the final word of the message.
REQ-008 SHALL have port in_nbytes, input, 2: valid bytes in the final word; 0 means 4 bytes, 1-3 mean 1-3 bytes; valid bytes are MSB-aligned; ignored unless in_last=1.
REQ-009 SHALL have port in_ready, output, 1: the padder accepts a word this cycle.
REQ-010 SHALL have port block_out, output, 512: padded block; word 0 is in [511:480] and word 15 is in [31:0]; it connects to the scheduler's message_block input.
REQ-011 SHALL have port block_valid, output, 1: block_out is valid.
REQ-012 SHALL have port block_ready, input, 1: the consumer accepts the block.
REQ-013 SHALL have port block_last, output, 1: the current block is the final block of the message; valid only while block_valid=1.

Function
REQ-014 SHALL transfer a word only when in_valid and in_ready are both 1 on a clock edge, and a block only when block_valid and block_ready are both 1 on a clock edge.
REQ-015 SHALL use the states ACCUM, EMIT and EMIT_EXTRA; in_ready=1 only in ACCUM; block_valid=1 only in EMIT and EMIT_EXTRA.
REQ-016 SHALL store accepted words at an index wi (0-15), starting at 0, and increment wi per word.
REQ-017 SHALL, on a non-last word written at wi=15, go to EMIT with block_last=0 on the next cycle.
REQ-018 SHALL keep a 64-bit message bit-length counter that adds 32 per non-last word and 8*bytes for the last word; the counter wraps modulo 2^64.
REQ-019 SHALL, on a last word with fewer than 4 bytes at wi=k, zero the invalid bytes and place 0x80 in the byte immediately after the last valid byte.
REQ-020 SHALL, on a last word with 4 bytes at wi=k, place 0x80000000 in word k+1 when k<15.
REQ-021 SHALL, when the 0x80 byte lands in word 13 or lower, zero-fill the remaining words up to word 13 and place the length in words 14 (high) and 15 (low); block_last=1; no extra block is produced.
REQ-022 SHALL otherwise zero-fill the first block, emit it with block_last=0, then enter EMIT_EXTRA; the extra block is all zeros plus the length in words 14 and 15, except that for k=15 with 4 bytes, word 0 of the extra block is 0x80000000; the extra block has block_last=1.
REQ-023 SHALL set block_valid one cycle after the accepting edge; block_out and block_last SHALL hold stable until the block handshake.
REQ-024 SHALL, on a block handshake in EMIT with block_last=0 and no extra block pending, return to ACCUM next cycle with wi=0 and the length counter retained.
REQ-025 SHALL, on a block handshake with block_last=1, return to ACCUM with wi=0 and the length counter cleared.
REQ-026 SHALL, on a handshake in EMIT when an extra block is pending, present the extra block with block_valid=1 on the next cycle, with no bubble in which block_valid=0.
REQ-027 SHALL not accept input (in_ready=0) while a block is pending; in_valid asserted in that state is not consumed.
REQ-028 SHALL not support zero-length messages; every message SHALL contain at least one word with in_last=1.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set state=ACCUM, wi=0, length=0, block_valid=0, block_last=0, block_out=0, and in_ready=1 from the first cycle after reset.
REQ-030 SHALL, on a reset in the middle of a message or block, discard the partial message and any pending block; no block is emitted for it.

Configuration
REQ-031 SHALL, when SHA256_PADDER_BLKCNT_EN is defined, add output blk_count[31:0], which resets to 0, increments on every block handshake, and wraps modulo 2^32.
REQ-032 SHALL, when SHA256_PADDER_BLKCNT_EN is undefined, have no blk_count port, with all other behaviour identical.

Verification
REQ-033 SHALL cover: "abc" sent as 0x61626300 with in_last=1, in_nbytes=3 -> one block, word0=0x61626380, words1-14=0, word15=0x00000018, block_last=1.
REQ-034 SHALL cover: a 56-byte message (14 words, last with in_nbytes=0) -> block1 has word14=0x80000000, word15=0, block_last=0; block2 is all zero except word15=0x000001C0, block_last=1.
REQ-035 SHALL cover: a 64-byte message -> block1 holds the 16 data words with block_last=0; block2 has word0=0x80000000 and word15=0x00000200, block_last=1; block_valid has no gap between the blocks.
REQ-036 SHALL cover: block_ready held 0 for 10 cycles with in_valid=1 -> block_out is stable, in_ready=0, no words are lost, and the next message pads correctly.
REQ-037 SHALL cover: rst pulsed after 5 words are accepted -> block_valid=0, in_ready=1 the next cycle; a following "abc" message yields the REQ-033 block.
REQ-038 SHALL cover, with SHA256_PADDER_BLKCNT_EN defined: the scenarios of REQ-033 and REQ-034 in sequence -> blk_count=3.
